// File: rtl/rab_pkg.sv
// Shared RAB types: the miss-queue entry layout and the drop counter width.
package rab_pkg;

    localparam int unsigned RAB_MISS_DROP_CNT_W = 16;
    localparam int unsigned RAB_AXI_ADDR_W      = 40;
    localparam int unsigned RAB_AXI_ID_W        = 8;

    typedef struct packed {
        logic [RAB_AXI_ADDR_W-1:0] addr;
        logic [RAB_AXI_ID_W-1:0]   id;
        logic                      port;
    } rab_miss_entry_t;

endpackage

// File: rtl/rab_sat_cnt.sv
// Saturating up-counter with synchronous clear; an increment in the same
// cycle as a clear wins and leaves the counter at 1.
module rab_sat_cnt #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clk_CI,
    input  logic             Rst_RBI,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (inc_i) begin
            if (clr_i) begin
                cnt_next = WIDTH'(1);
            end else if (cnt_reg != CNT_MAX) begin
                cnt_next = cnt_reg + WIDTH'(1);
            end
        end else if (clr_i) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt_o = cnt_reg;

endmodule

// File: rtl/rab_miss_queue.sv
// Miss log FIFO between the RAB lookup FSM and the host: first-word-fall-through
// head register, sticky overflow flag and saturating drop counter.
module rab_miss_queue
    import rab_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 40,
    parameter int unsigned AXI_ID_WIDTH   = 8,
    parameter int unsigned DEPTH          = 16
) (
    input  logic                           Clk_CI,
    input  logic                           Rst_RBI,
    input  logic                           miss_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0]      miss_addr_i,
    input  logic [AXI_ID_WIDTH-1:0]        miss_id_i,
    input  logic                           miss_port_i,
    output logic                           entry_valid_o,
    input  logic                           entry_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0]      entry_addr_o,
    output logic [AXI_ID_WIDTH-1:0]        entry_id_o,
    output logic                           entry_port_o,
    output logic [$clog2(DEPTH):0]         count_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic                           overflow_o,
    output logic [RAB_MISS_DROP_CNT_W-1:0] drop_cnt_o,
    input  logic                           clear_i,
    input  logic                           flush_i,
    output logic                           irq_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic            overflow_reg;
    rab_miss_entry_t mem_reg [DEPTH];
    rab_miss_entry_t head_reg;
    rab_miss_entry_t wr_entry;

    logic full, empty, push, pop, drop, bypass;

    // Status comes from the pointers alone, so it has no input-to-output path.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign pop  = !empty && entry_ready_i && !flush_i;
    assign push = miss_valid_i && !flush_i && (!full || pop);
    assign drop = miss_valid_i && !flush_i && full && !pop;

    assign wr_ptr_next = flush_i ? '0 : wr_ptr_reg + PW'(push);
    assign rd_ptr_next = flush_i ? '0 : rd_ptr_reg + PW'(pop);

    // The pushed entry lands in the slot that becomes the head only when the
    // queue is (or is about to be) empty; forward it so it is visible next cycle.
    assign bypass = push && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0]);

    always_comb begin
        wr_entry      = '0;
        wr_entry.addr = RAB_AXI_ADDR_W'(miss_addr_i);
        wr_entry.id   = RAB_AXI_ID_W'(miss_id_i);
        wr_entry.port = miss_port_i;
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (clear_i) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (push) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= wr_entry;
        end
    end

    // Registered read at the next head address; rereading an untouched slot
    // keeps the head stable while the host stalls.
    always_ff @(posedge Clk_CI) begin
        if (bypass) begin
            head_reg <= wr_entry;
        end else begin
            head_reg <= mem_reg[rd_ptr_next[AW-1:0]];
        end
    end

    rab_sat_cnt #(
        .WIDTH (RAB_MISS_DROP_CNT_W)
    ) i_drop_cnt (
        .Clk_CI  (Clk_CI),
        .Rst_RBI (Rst_RBI),
        .inc_i   (drop),
        .clr_i   (clear_i),
        .cnt_o   (drop_cnt_o)
    );

    assign entry_valid_o = !empty;
    assign entry_addr_o  = AXI_ADDR_WIDTH'(head_reg.addr);
    assign entry_id_o    = AXI_ID_WIDTH'(head_reg.id);
    assign entry_port_o  = head_reg.port;
    assign count_o       = wr_ptr_reg - rd_ptr_reg;
    assign full_o        = full;
    assign empty_o       = empty;
    assign overflow_o    = overflow_reg;
    assign irq_o         = !empty || overflow_reg;

endmodule

// File: tb/tb_rab_miss_queue.sv
// Randomised bench for rab_miss_queue against a queue-based reference model.
module tb_rab_miss_queue;

    localparam int DEPTH = 16;

    typedef struct {
        logic [39:0] a;
        logic [7:0]  id;
        logic        p;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        miss_valid = 1'b0;
    logic [39:0] miss_addr = '0;
    logic [7:0]  miss_id = '0;
    logic        miss_port = 1'b0;
    logic        entry_ready = 1'b0;
    logic        clear = 1'b0;
    logic        flush = 1'b0;

    logic        entry_valid;
    logic [39:0] entry_addr;
    logic [7:0]  entry_id;
    logic        entry_port;
    logic [4:0]  count;
    logic        full, empty, overflow, irq;
    logic [15:0] drop_cnt;

    rab_miss_queue #(
        .AXI_ADDR_WIDTH (40),
        .AXI_ID_WIDTH   (8),
        .DEPTH          (DEPTH)
    ) dut (
        .Clk_CI        (clk),
        .Rst_RBI       (rst_n),
        .miss_valid_i  (miss_valid),
        .miss_addr_i   (miss_addr),
        .miss_id_i     (miss_id),
        .miss_port_i   (miss_port),
        .entry_valid_o (entry_valid),
        .entry_ready_i (entry_ready),
        .entry_addr_o  (entry_addr),
        .entry_id_o    (entry_id),
        .entry_port_o  (entry_port),
        .count_o       (count),
        .full_o        (full),
        .empty_o       (empty),
        .overflow_o    (overflow),
        .drop_cnt_o    (drop_cnt),
        .clear_i       (clear),
        .flush_i       (flush),
        .irq_o         (irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b1;

    // Reference model: the queue contents plus the two sticky status values.
    ent_t q[$];
    bit   ovf_m = 1'b0;
    int   drop_m = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        bit pop_m, drop_ev;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            ovf_m  = 1'b0;
            drop_m = 0;
        end else begin
            pop_m   = (q.size() > 0) && entry_ready && !flush;
            drop_ev = miss_valid && !flush && (q.size() == DEPTH) && !pop_m;
            if (flush) begin
                q.delete();
            end else begin
                if (pop_m) begin
                    e = q.pop_front();
                    $display("pop  addr=%010h id=%02h port=%0d", e.a, e.id, e.p);
                end
                if (miss_valid && !drop_ev) begin
                    e.a = miss_addr; e.id = miss_id; e.p = miss_port;
                    q.push_back(e);
                end
            end
            if (drop_ev) begin
                ovf_m  = 1'b1;
                drop_m = clear ? 1 : (drop_m < 65535 ? drop_m + 1 : drop_m);
            end else if (clear) begin
                ovf_m  = 1'b0;
                drop_m = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid",    64'(entry_valid), 64'(q.size() != 0));
            chk("count",    64'(count),       64'(q.size()));
            chk("full",     64'(full),        64'(q.size() == DEPTH));
            chk("empty",    64'(empty),       64'(q.size() == 0));
            chk("overflow", 64'(overflow),    64'(ovf_m));
            chk("drop_cnt", 64'(drop_cnt),    64'(drop_m));
            chk("irq",      64'(irq),         64'((q.size() != 0) || ovf_m));
            if (q.size() != 0) begin
                chk("head_addr", 64'(entry_addr), 64'(q[0].a));
                chk("head_id",   64'(entry_id),   64'(q[0].id));
                chk("head_port", 64'(entry_port), 64'(q[0].p));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_miss();
        miss_addr = {8'($urandom), 32'($urandom)};
        miss_id   = 8'($urandom);
        miss_port = 1'($urandom);
    endtask

    ent_t new_e;
    int   pushes;
    int   guard;

    initial begin
        #2;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(entry_valid), 64'd0);
        chk("rst_irq",   64'(irq), 64'd0);
        chk("rst_full",  64'(full), 64'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Single miss becomes visible one cycle later.
        miss_valid = 1'b1; miss_addr = 40'h12_3456_7000; miss_id = 8'h05; miss_port = 1'b1;
        step();
        miss_valid = 1'b0;
        chk("one_valid", 64'(entry_valid), 64'd1);
        chk("one_addr",  64'(entry_addr),  64'h12_3456_7000);
        chk("one_id",    64'(entry_id),    64'h05);
        chk("one_port",  64'(entry_port),  64'd1);
        chk("one_count", 64'(count),       64'd1);
        chk("one_irq",   64'(irq),         64'd1);

        // Fill to 16 and drop three.
        miss_valid = 1'b1;
        repeat (15) begin rand_miss(); step(); end
        chk("fill_full",  64'(full),  64'd1);
        chk("fill_count", 64'(count), 64'd16);
        repeat (3) begin rand_miss(); step(); end
        miss_valid = 1'b0;
        chk("fill_ovf",  64'(overflow),   64'd1);
        chk("fill_drop", 64'(drop_cnt),   64'd3);
        chk("fill_head", 64'(entry_addr), 64'h12_3456_7000);

        // Push and pop together while full.
        rand_miss();
        new_e.a = miss_addr; new_e.id = miss_id; new_e.p = miss_port;
        miss_valid = 1'b1; entry_ready = 1'b1;
        step();
        miss_valid = 1'b0;
        chk("fullpp_count", 64'(count),    64'd16);
        chk("fullpp_drop",  64'(drop_cnt), 64'd3);
        repeat (15) step();
        entry_ready = 1'b0;
        chk("fullpp_head", 64'(entry_addr), 64'(new_e.a));
        entry_ready = 1'b1;
        step();
        entry_ready = 1'b0;
        chk("fullpp_empty", 64'(empty), 64'd1);

        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_ovf", 64'(overflow), 64'd0);

        // Wrap-around with random host back-pressure.
        pushes = 0;
        guard = 0;
        while (pushes < 40 && guard < 2000) begin
            miss_valid = 1'($urandom);
            rand_miss();
            entry_ready = ($urandom % 4) != 0;
            if (miss_valid) pushes++;
            step();
            guard++;
        end
        miss_valid = 1'b0;
        entry_ready = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 64) begin
            step();
            guard++;
        end
        entry_ready = 1'b0;
        chk("wrap_empty", 64'(empty), 64'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;

        // Drop counter: clear racing a drop, then saturation.
        miss_valid = 1'b1;
        repeat (16) begin rand_miss(); step(); end
        repeat (5) begin rand_miss(); step(); end
        chk("drop5", 64'(drop_cnt), 64'd5);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clrdrop_cnt", 64'(drop_cnt), 64'd1);
        chk("clrdrop_ovf", 64'(overflow), 64'd1);
        chk_en = 1'b0;
        repeat (65530) step();
        chk_en = 1'b1;
        repeat (7) step();
        chk("sat_cnt", 64'(drop_cnt), 64'hFFFF);
        miss_valid = 1'b0;

        // Flush with a same-cycle push.
        flush = 1'b1;
        step();
        flush = 1'b0;
        miss_valid = 1'b1;
        repeat (7) begin rand_miss(); step(); end
        flush = 1'b1;
        rand_miss();
        step();
        flush = 1'b0;
        miss_valid = 1'b0;
        chk("flush_empty", 64'(empty),    64'd1);
        chk("flush_count", 64'(count),    64'd0);
        chk("flush_drop",  64'(drop_cnt), 64'hFFFF);
        chk("flush_ovf",   64'(overflow), 64'd1);

        // Asynchronous reset with four entries queued.
        miss_valid = 1'b1;
        repeat (4) begin rand_miss(); step(); end
        miss_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_empty", 64'(empty), 64'd1);
        chk("arst_irq",   64'(irq),   64'd0);
        chk("arst_count", 64'(count), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        miss_valid = 1'b1; miss_addr = 40'hAB_CDEF_0123; miss_id = 8'h3C; miss_port = 1'b0;
        step();
        miss_valid = 1'b0;
        chk("post_rst_valid", 64'(entry_valid), 64'd1);
        chk("post_rst_addr",  64'(entry_addr),  64'hAB_CDEF_0123);
        chk("post_rst_count", 64'(count),       64'd1);

        // Mixed random traffic including occasional clear and flush.
        repeat (400) begin
            miss_valid  = 1'($urandom);
            rand_miss();
            entry_ready = 1'($urandom);
            clear       = ($urandom % 24) == 0;
            flush       = ($urandom % 32) == 0;
            step();
        end
        miss_valid = 1'b0; entry_ready = 1'b0; clear = 1'b0; flush = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
